// File: rtl/id_ex_stage_if.sv
// Bundle of every id_ex_stage signal except clock and reset.
// master: the environment around the stage (IF/ID, register file, writeback, hazard control).
// slave : the stage itself.
interface id_ex_stage_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    // IF/ID side
    logic [15:0]   id_instr;
    logic          id_valid;

    // register-file read ports
    logic [AW-1:0] p0_addr;
    logic [AW-1:0] p1_addr;
    logic          re0;
    logic          re1;
    logic [DW-1:0] p0;
    logic [DW-1:0] p1;

    // writeback, shared with the register-file write port
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    // pipeline control
    logic          hold;
    logic          flush;
    logic          stall_out;

    // ID/EX register outputs
    logic          ex_valid;
    logic [3:0]    ex_op;
    logic [AW-1:0] ex_rd;
    logic          ex_we;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [DW-1:0] ex_imm;
    logic [15:0]   haz_cnt;

    modport master (
        output id_instr, id_valid, p0, p1, wb_we, wb_addr, wb_data, hold, flush,
        input  p0_addr, p1_addr, re0, re1, stall_out,
        input  ex_valid, ex_op, ex_rd, ex_we, ex_a, ex_b, ex_imm, haz_cnt
    );

    modport slave (
        input  id_instr, id_valid, p0, p1, wb_we, wb_addr, wb_data, hold, flush,
        output p0_addr, p1_addr, re0, re1, stall_out,
        output ex_valid, ex_op, ex_rd, ex_we, ex_a, ex_b, ex_imm, haz_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline stage.
// The stage decodes the IF/ID instruction into register-file read addresses, forwards
// same-cycle writeback data that the register file only exposes a cycle later, and turns
// a load followed directly by a user of the loaded register into one bubble plus an
// upstream stall. The ID/EX register feeds the ALU.
// Optional feature: define ID_EX_HAZ_CNT_EN to build a saturating count of load-use
// bubbles on haz_cnt. Without the macro, haz_cnt is tied to zero.
module id_ex_stage #(
    parameter int         DW    = 16,
    parameter int         AW    = 4,
    parameter logic [3:0] OP_LW = 4'h8,
    parameter logic [3:0] OP_SW = 4'h9
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic          valid;
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic          we;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
    } ex_t;

    logic [3:0]    dec_op;
    logic [AW-1:0] dec_rd;
    logic [AW-1:0] dec_rs;
    logic [AW-1:0] dec_rt;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;
    logic          hazard;
    logic          stall;
    ex_t           ex_q;
    ex_t           ex_d;
    ex_t           ex_cap;

    // Field split and read-port addressing; a store reads its data register through port 1.
    always_comb begin
        dec_op   = bus.id_instr[15:12];
        dec_rd   = AW'(bus.id_instr[11:8]);
        dec_rs   = AW'(bus.id_instr[7:4]);
        dec_rt   = AW'(bus.id_instr[3:0]);
        rd_addr0 = dec_rs;
        rd_addr1 = (dec_op == OP_SW) ? dec_rd : dec_rt;
    end

    assign bus.p0_addr = rd_addr0;
    assign bus.p1_addr = rd_addr1;
    assign bus.re0     = bus.id_valid;
    assign bus.re1     = bus.id_valid;

    // Forward the value being written this cycle; R0 is constant zero and is never forwarded.
    always_comb begin
        opnd_a = bus.p0;
        opnd_b = bus.p1;
        if (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == rd_addr0)) begin
            opnd_a = bus.wb_data;
        end
        if (bus.wb_we && (bus.wb_addr != '0) && (bus.wb_addr == rd_addr1)) begin
            opnd_b = bus.wb_data;
        end
    end

    // A load in EX cannot supply its result yet, so a reader of its destination must wait a cycle.
    always_comb begin
        hazard = bus.id_valid && ex_q.valid && (ex_q.op == OP_LW) && (ex_q.rd != '0) &&
                 ((ex_q.rd == rd_addr0) || (ex_q.rd == rd_addr1));
        stall  = hazard && !bus.flush && !bus.hold;
    end

    assign bus.stall_out = stall;

    // Decoded contents that the ID/EX register takes when the instruction advances normally.
    always_comb begin
        ex_cap       = '0;
        ex_cap.valid = 1'b1;
        ex_cap.op    = dec_op;
        ex_cap.rd    = dec_rd;
        ex_cap.we    = (dec_op != OP_SW) && (dec_rd != '0);
        ex_cap.a     = opnd_a;
        ex_cap.b     = opnd_b;
        ex_cap.imm   = {{(DW-8){bus.id_instr[7]}}, bus.id_instr[7:0]};
    end

    // Next ID/EX contents: flush beats hold, hold beats the hazard bubble; an empty slot is a bubble.
    always_comb begin
        ex_d = '0;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d = '0;
        end else if (bus.id_valid) begin
            ex_d = ex_cap;
        end
    end

    // ID/EX pipeline register; reset clears whatever was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid = ex_q.valid;
    assign bus.ex_op    = ex_q.op;
    assign bus.ex_rd    = ex_q.rd;
    assign bus.ex_we    = ex_q.we;
    assign bus.ex_a     = ex_q.a;
    assign bus.ex_b     = ex_q.b;
    assign bus.ex_imm   = ex_q.imm;

`ifdef ID_EX_HAZ_CNT_EN
    logic [15:0] haz_cnt_q;

    // Count load-use bubbles actually inserted; sticks at all-ones, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haz_cnt_q <= 16'h0000;
        end else if (stall && (haz_cnt_q != 16'hFFFF)) begin
            haz_cnt_q <= haz_cnt_q + 16'd1;
        end
    end

    assign bus.haz_cnt = haz_cnt_q;
`else
    assign bus.haz_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver applies one input set per cycle and pushes the
// expected response; a monitor pops each entry and compares the read-port/stall outputs
// mid-cycle and the ID/EX outputs just after the following edge.
module tb_id_ex_stage;

    localparam logic [3:0] OP_LW = 4'h8;
    localparam logic [3:0] OP_SW = 4'h9;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic        we;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
    } exp_ex_t;

    typedef struct packed {
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic        re;
        logic        stall;
        exp_ex_t     ex;
        logic [15:0] haz;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;

    id_ex_stage_if #(.DW(16), .AW(4)) bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // register file the stage reads from: synchronous write, combinational read
    logic [15:0] rf [16] = '{default: 16'h0000};

    always @(posedge clk) begin
        if (bus.wb_we && bus.wb_addr != 4'd0) rf[bus.wb_addr] <= bus.wb_data;
    end

    assign bus.p0 = rf[bus.p0_addr];
    assign bus.p1 = rf[bus.p1_addr];

    item_t   sb[$];
    exp_ex_t m_ex;
    logic [15:0] m_haz;
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // one cycle of stimulus plus the reference response
    task automatic step(input logic [15:0] instr, input logic vld, input logic we,
                        input logic [3:0] wa, input logic [15:0] wd,
                        input logic hld, input logic fl);
        item_t   it;
        exp_ex_t nxt;
        logic [3:0] op, rd, rs, rt, a0, a1;
        logic [15:0] va, vb;
        logic hz;
        @(posedge clk);
        #2;
        bus.id_instr = instr;
        bus.id_valid = vld;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.hold     = hld;
        bus.flush    = fl;
        #1;
        op = instr[15:12];
        rd = instr[11:8];
        rs = instr[7:4];
        rt = instr[3:0];
        a0 = rs;
        a1 = (op == OP_SW) ? rd : rt;
        va = (we && wa != 4'd0 && wa == a0) ? wd : rf[a0];
        vb = (we && wa != 4'd0 && wa == a1) ? wd : rf[a1];
        hz = vld && m_ex.valid && m_ex.op == OP_LW && m_ex.rd != 4'd0 &&
             (m_ex.rd == a0 || m_ex.rd == a1);
        if (fl)        nxt = '0;
        else if (hld)  nxt = m_ex;
        else if (hz)   nxt = '0;
        else if (!vld) nxt = '0;
        else begin
            nxt.valid = 1'b1;
            nxt.op    = op;
            nxt.rd    = rd;
            nxt.we    = (op != OP_SW) && (rd != 4'd0);
            nxt.a     = va;
            nxt.b     = vb;
            nxt.imm   = {{8{instr[7]}}, instr[7:0]};
        end
        it.a0    = a0;
        it.a1    = a1;
        it.re    = vld;
        it.stall = hz && !fl && !hld;
`ifdef ID_EX_HAZ_CNT_EN
        if (it.stall && m_haz != 16'hFFFF) m_haz = m_haz + 16'd1;
`endif
        it.ex  = nxt;
        it.haz = m_haz;
        m_ex   = nxt;
        sb.push_back(it);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ex_valid"}, 32'(bus.ex_valid), 32'd0);
        chk({tag, " ex_op"},    32'(bus.ex_op),    32'd0);
        chk({tag, " ex_rd"},    32'(bus.ex_rd),    32'd0);
        chk({tag, " ex_we"},    32'(bus.ex_we),    32'd0);
        chk({tag, " ex_a"},     32'(bus.ex_a),     32'd0);
        chk({tag, " ex_b"},     32'(bus.ex_b),     32'd0);
        chk({tag, " ex_imm"},   32'(bus.ex_imm),   32'd0);
        chk({tag, " haz_cnt"},  32'(bus.haz_cnt),  32'd0);
    endtask

    // asynchronous reset in mid-stream, checked before any clock edge
    task automatic reset_mid();
        @(posedge clk);
        #2;
        bus.id_valid = 1'b0;
        bus.hold     = 1'b0;
        bus.flush    = 1'b0;
        bus.wb_we    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid");
        m_ex  = '0;
        m_haz = 16'h0000;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // monitor
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                chk("p0_addr",   32'(bus.p0_addr),   32'(it.a0));
                chk("p1_addr",   32'(bus.p1_addr),   32'(it.a1));
                chk("re0",       32'(bus.re0),       32'(it.re));
                chk("re1",       32'(bus.re1),       32'(it.re));
                chk("stall_out", 32'(bus.stall_out), 32'(it.stall));
                @(posedge clk);
                #1;
                chk("ex_valid", 32'(bus.ex_valid), 32'(it.ex.valid));
                chk("ex_op",    32'(bus.ex_op),    32'(it.ex.op));
                chk("ex_rd",    32'(bus.ex_rd),    32'(it.ex.rd));
                chk("ex_we",    32'(bus.ex_we),    32'(it.ex.we));
                chk("ex_a",     32'(bus.ex_a),     32'(it.ex.a));
                chk("ex_b",     32'(bus.ex_b),     32'(it.ex.b));
                chk("ex_imm",   32'(bus.ex_imm),   32'(it.ex.imm));
                chk("haz_cnt",  32'(bus.haz_cnt),  32'(it.haz));
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    // driver
    initial begin
        rst_n        = 1'b0;
        bus.id_instr = 16'h0000;
        bus.id_valid = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = 4'd0;
        bus.wb_data  = 16'h0000;
        bus.hold     = 1'b0;
        bus.flush    = 1'b0;
        m_ex         = '0;
        m_haz        = 16'h0000;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // bypass: RF holds 0011 in R3, writeback of BEEF to R3 in the same cycle wins
        step(16'h0000, 1'b0, 1'b1, 4'd3, 16'h0011, 1'b0, 1'b0);
        step({4'h1, 4'd1, 4'd3, 4'd4}, 1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0);
        step({4'h1, 4'd1, 4'd0, 4'd4}, 1'b1, 1'b1, 4'd0, 16'h5555, 1'b0, 1'b0);

        // load-use: LW R5 then ADD R1,R5,R2 -> one stall/bubble, then ADD with forwarded load data
        step({OP_LW, 4'd5, 4'd2, 4'd0}, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        step({4'h1, 4'd1, 4'd5, 4'd2},  1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        step({4'h1, 4'd1, 4'd5, 4'd2},  1'b1, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0);

        // flush together with a hazard: no stall, bubble, counter untouched
        step({OP_LW, 4'd6, 4'd1, 4'd0}, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        step({4'h2, 4'd2, 4'd6, 4'd6},  1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);

        // hold for three cycles with changing instructions, then capture on release
        step({4'h3, 4'd4, 4'd3, 4'd5},  1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        step({4'h4, 4'd7, 4'd1, 4'd2},  1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        step({4'h5, 4'd8, 4'd2, 4'd3},  1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        step({4'h6, 4'd9, 4'd3, 4'd1},  1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
        step({4'h7, 4'd10, 4'hF, 4'hE}, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);

        // store reads its data register on port 1; load to R0 never stalls its user
        step({OP_SW, 4'd7, 4'd2, 4'd0}, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        step({OP_LW, 4'd0, 4'd2, 4'd0}, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        step({4'h1, 4'd3, 4'd0, 4'd0},  1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);

        // load followed by an invalid slot: no stall
        step({OP_LW, 4'd2, 4'd1, 4'd0}, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        step({4'h1, 4'd3, 4'd2, 4'd2},  1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] op, rd, rs, rt;
            case ($urandom_range(0, 3))
                0:       op = OP_LW;
                1:       op = OP_SW;
                default: op = 4'($urandom);
            endcase
            rd = 4'($urandom_range(0, 3));
            rs = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            rt = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            step({op, rd, rs, rt}, $urandom_range(0, 6) != 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            if (i == 200) reset_mid();
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
